led_scan: RTL and testbench
===========================

# led_scan

Multiplexed 7-segment display driver that sits directly downstream of the clock divider and consumes its `clkled` square wave as a scan-rate reference. It time-multiplexes a 16-bit hex value across four common-anode digits, inserts an anti-ghosting blank gap between digits, and latches the displayed value once per frame so the display never tears. All logic runs on the system clock; `clkled` is used only as a data-level input and is never used as a clock.

## Interface
- `NDIGITS`, 4: number of digits scanned; the design supports only 4.
- `GAP_CYCLES`, 16: clk cycles with all anodes off between digits; range 1..255, and it must be less than the `clkled` half-period.
- `ACTIVE_LOW`, 1: 1 means `seg`, `dpo` and `an` are driven active-low; 0 means active-high.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `clkled`  in  1  scan reference from the clock divider, synchronous to `clk`; each rising level is one scan tick.
- `value`  in  16  display value; digit i shows `value[4i+3:4i]`, and digit 3 is leftmost.
- `dp`  in  4  decimal point per digit.
- `blank_lz`  in  1  enables leading-zero blanking.
- `seg`  out  7  segments, `seg[0]`=a … `seg[6]`=g.
- `dpo`  out  1  decimal point of the active digit.
- `an`  out  4  digit enables, one-hot when active.
- `frame`  out  1  one-cycle pulse when a new frame starts.

## Operation
- Tick detection: `prev` register holds the previous `clkled` level. `tick = clkled & ~prev`.
- FSM states:
  - **SHOW**: `an[idx]` active, `seg`/`dpo` show digit `idx`. On `tick`, go to GAP and load the gap counter with `GAP_CYCLES-1`.
  - **GAP**: `an`, `seg` and `dpo` all inactive; the counter decrements each cycle. When the counter reaches 0, `idx <= idx+1` (mod 4), then go to SHOW.
  - A `tick` that arrives while in GAP is ignored. It is not queued.
- Frame latch: on the GAP→SHOW transition where the new `idx` is 0:
  - `value`, `dp` and `blank_lz` are captured into shadow registers;
  - `frame` pulses for 1 cycle.
- The displayed digit always comes from the shadow registers and never from the live inputs.
- Leading-zero blanking: digit i (i≥1) is blanked (all segments off, `dp` still honoured) when shadow `blank_lz`=1 and shadow nibbles i..3 are all 0. Digit 0 is never blanked.
- Hex decode, active-high form `{g,f,e,d,c,b,a}`:

  | Digit | Code |
  |---|---|
  | 0 | 0111111 |
  | 1 | 0000110 |
  | 2 | 1011011 |
  | 3 | 1001111 |
  | 4 | 1100110 |
  | 5 | 1101101 |
  | 6 | 1111101 |
  | 7 | 0000111 |
  | 8 | 1111111 |
  | 9 | 1101111 |
  | A | 1110111 |
  | b | 1111100 |
  | C | 0111001 |
  | d | 1011110 |
  | E | 1111001 |
  | F | 1110001 |

- `ACTIVE_LOW` inverts `seg`, `dpo` and `an` at the output registers.

## Timing
- Reset (synchronous) sets:
  - state GAP, counter 0, `idx`=3, `prev`=0, shadows 0;
  - `an`, `seg`, `dpo` inactive (all ones when `ACTIVE_LOW`=1); `frame`=0.
- First cycle after reset: the counter is 0, so the FSM goes to SHOW with `idx`=0. This latches the shadows and pulses `frame`. The first frame starts without waiting for a tick.
- All outputs are registered.
  - Tick sampled at edge T → `an` inactive from edge T+1.
  - New digit enabled from edge T+1+`GAP_CYCLES`.
  - `frame` is high during the same cycle in which `an[0]` first goes active.
- Period: a digit is shown from one `clkled` rise to the next, minus the gap. A full frame equals 4 `clkled` periods.
- If `clkled` is held constant, the current digit stays lit indefinitely. There is no timeout.
- Reset asserted in any state takes effect at the next edge and overrides any tick or counter event in that cycle.

## Structure
- Shared package `led_pkg` holds:
  - state encoding (SHOW, GAP);
  - the 16-entry hex segment table;
  - the `seg` bit-order constants.
- Sub-module `hex7seg` is a purely combinational nibble-to-segment decoder (active-high, no blanking). `led_scan` instantiates it once. Blanking, polarity and registering stay in `led_scan`.

## Test plan
1. **Reset:** with `ACTIVE_LOW`=1, assert `rst` for 3 cycles, then release.
   - During reset: `an`=1111, `seg`=1111111, `dpo`=1.
   - One cycle after release: `an`=1110, `frame`=1.
2. **Scan:** `value`=0x1234, `dp`=0000, `blank_lz`=0, `GAP_CYCLES`=16, 4 `clkled` rises.
   - After each rise: `an` is inactive for exactly 16 cycles.
   - Digits then appear in order 4, 3, 2, 1 on `an`=1110, 1101, 1011, 0111.
   - Active-low `seg` values are 0011001, 0110000, 0100100, 1111001.
3. **Leading-zero blanking:** `value`=0x0008, `blank_lz`=1.
   - Digits 3..1 show `seg`=1111111 while their anode is active.
   - Digit 0 shows 0000000.
   - `value`=0x0000: digit 0 shows 1000000.
4. **Tearing:** change `value` from 0x1111 to 0xFFFF while `idx`=2.
   - Digits 2 and 3 still show 1.
   - After `frame` pulses, all digits show F (active-low 0001110).
5. **Gap tick:** issue a `clkled` rise 5 cycles into GAP.
   - `idx` advances exactly once.
   - The gap still lasts 16 cycles.
6. **Reset mid-operation:** assert `rst` during GAP with `idx`=1.
   - Next cycle: all outputs inactive.
   - After release: scan restarts at `idx`=0 with a `frame` pulse.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner: FSM encoding,
// segment bit order and the active-high hex glyph table.
package led_pkg;

    typedef enum logic {
        ST_SHOW = 1'b0,
        ST_GAP  = 1'b1
    } state_t;

    // seg[SEG_A] is segment a, seg[SEG_G] is segment g
    localparam int SEG_A = 0;
    localparam int SEG_G = 6;
    localparam int SEG_W = SEG_G - SEG_A + 1;

    // Glyphs in {g,f,e,d,c,b,a} order, 1 = segment lit
    localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    function automatic logic [SEG_W-1:0] hex_seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage

// File: rtl/led_scan_hex7seg.sv
// Combinational nibble-to-segment decoder, active-high, no blanking.
module hex7seg
    import led_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    assign seg = hex_seg(nibble);

endmodule

// File: rtl/led_scan.sv
// Four-digit multiplexed 7-segment driver stepped by clkled rising levels,
// with a blank gap between digits and a once-per-frame shadow latch.
module led_scan
    import led_pkg::*;
#(
    parameter int NDIGITS    = 4,
    parameter int GAP_CYCLES = 16,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clkled,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic [NDIGITS-1:0]     dp,
    input  logic                   blank_lz,
    output logic [SEG_W-1:0]       seg,
    output logic                   dpo,
    output logic [NDIGITS-1:0]     an,
    output logic                   frame
);

    localparam logic [7:0]         GAP_LOAD = 8'(GAP_CYCLES - 1);
    localparam logic [SEG_W-1:0]   SEG_POL  = {SEG_W{ACTIVE_LOW}};
    localparam logic [NDIGITS-1:0] AN_POL   = {NDIGITS{ACTIVE_LOW}};

    state_t                 state_reg, state_next;
    logic [7:0]             cnt_reg, cnt_next;
    logic [1:0]             idx_reg, idx_next;
    logic                   latch_next;
    logic                   prev_reg;
    logic                   tick;

    logic [4*NDIGITS-1:0]   sh_value_reg;
    logic [NDIGITS-1:0]     sh_dp_reg;
    logic                   sh_blz_reg;
    logic                   frame_pend_reg;

    logic [SEG_W-1:0]       seg_reg;
    logic                   dpo_reg;
    logic [NDIGITS-1:0]     an_reg;
    logic                   frame_reg;

    logic [3:0]             cur_nibble;
    logic [SEG_W-1:0]       dec_seg;
    logic [NDIGITS-1:0]     blank_vec;
    logic [SEG_W-1:0]       seg_on;
    logic [NDIGITS-1:0]     an_on;
    logic                   dp_on;

    assign tick = clkled & ~prev_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_GAP;
            cnt_reg   <= '0;
            idx_reg   <= 2'd3;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
        end
    end

    // Ticks seen during GAP are dropped, not queued
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        latch_next = 1'b0;
        case (state_reg)
            ST_SHOW: begin
                if (tick) begin
                    state_next = ST_GAP;
                    cnt_next   = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (cnt_reg == 8'd0) begin
                    idx_next   = idx_reg + 2'd1;
                    state_next = ST_SHOW;
                    latch_next = (idx_reg == 2'd3);
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            default: state_next = ST_GAP;
        endcase
    end

    // Digit i >= 1 blanks when it and every digit to its left is zero
    generate
        for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_blank
            if (gi == 0) begin : g_first
                assign blank_vec[gi] = 1'b0;
            end else begin : g_upper
                assign blank_vec[gi] = sh_blz_reg & ~|sh_value_reg[4*NDIGITS-1:4*gi];
            end
        end
    endgenerate

    assign cur_nibble = sh_value_reg[{idx_reg, 2'b00} +: 4];

    hex7seg u_dec (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        seg_on = '0;
        an_on  = '0;
        dp_on  = 1'b0;
        if (state_reg == ST_SHOW) begin
            seg_on = blank_vec[idx_reg] ? '0 : dec_seg;
            an_on  = NDIGITS'(1) << idx_reg;
            dp_on  = sh_dp_reg[idx_reg];
        end
    end

    // Outputs trail the FSM by one cycle; the frame pulse is delayed to match
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_reg       <= 1'b0;
            sh_value_reg   <= '0;
            sh_dp_reg      <= '0;
            sh_blz_reg     <= 1'b0;
            frame_pend_reg <= 1'b0;
            frame_reg      <= 1'b0;
            seg_reg        <= SEG_POL;
            dpo_reg        <= ACTIVE_LOW;
            an_reg         <= AN_POL;
        end else begin
            prev_reg       <= clkled;
            frame_pend_reg <= latch_next;
            frame_reg      <= frame_pend_reg;
            if (latch_next) begin
                sh_value_reg <= value;
                sh_dp_reg    <= dp;
                sh_blz_reg   <= blank_lz;
            end
            seg_reg <= seg_on ^ SEG_POL;
            dpo_reg <= dp_on ^ ACTIVE_LOW;
            an_reg  <= an_on ^ AN_POL;
        end
    end

    assign seg   = seg_reg;
    assign dpo   = dpo_reg;
    assign an    = an_reg;
    assign frame = frame_reg;

endmodule

// File: tb/tb_led_scan.sv
// Randomized bench for led_scan: a timestamp-based display model predicts
// every output on every cycle; one line is printed per displayed frame.
module tb_led_scan;

    localparam int G = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clkled = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp = 4'h0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic        dpo;
    logic [3:0]  an;
    logic        frame;

    led_scan #(
        .NDIGITS    (4),
        .GAP_CYCLES (G),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clkled   (clkled),
        .value    (value),
        .dp       (dp),
        .blank_lz (blank_lz),
        .seg      (seg),
        .dpo      (dpo),
        .an       (an),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    // Active-high glyphs {g,f,e,d,c,b,a}
    logic [6:0] glyph [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    int checks = 0;
    int errors = 0;
    int frames = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: edge index t, the edge from which the pending digit is lit,
    // which digit that is, the frame shadows and the last sampled clkled.
    int          t = 0;
    int          light_at = 0;
    int          digit = 0;
    logic [15:0] sh_v = 16'h0;
    logic [3:0]  sh_dp = 4'h0;
    logic        sh_blz = 1'b0;
    logic        m_prev = 1'b0;

    function automatic logic [6:0] lit_segs(input int d);
        logic [15:0] upper;
        upper = sh_v >> (4 * d);
        if (d > 0 && sh_blz && upper == 16'h0)
            return 7'h00;
        return glyph[upper[3:0]];
    endfunction

    task automatic cycle();
        logic       lit;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dpo;
        logic       e_frame;
        @(posedge clk);
        lit = !rst && (t >= light_at);
        e_an    = lit ? ~(4'b0001 << digit) : 4'hF;
        e_seg   = lit ? ~lit_segs(digit) : 7'h7F;
        e_dpo   = lit ? ~sh_dp[digit] : 1'b1;
        e_frame = lit && (t == light_at) && (digit == 0);
        if (rst) begin
            light_at = t + 2;
            digit    = 0;
            m_prev   = 1'b0;
        end else begin
            if (t == light_at - 1 && digit == 0) begin
                sh_v   = value;
                sh_dp  = dp;
                sh_blz = blank_lz;
            end
            if (clkled && !m_prev && t >= light_at) begin
                light_at = t + 1 + G;
                digit    = (digit + 1) % 4;
            end
            m_prev = clkled;
        end
        #1;
        chk("an", 16'(an), 16'(e_an));
        chk("seg", 16'(seg), 16'(e_seg));
        chk("dpo", 16'(dpo), 16'(e_dpo));
        chk("frame", 16'(frame), 16'(e_frame));
        if (e_frame) begin
            frames++;
            $display("frame %0d value=%h dp=%b blank_lz=%b", frames, sh_v, sh_dp, sh_blz);
        end
        t++;
    endtask

    task automatic run(input int n, input int hmin, input int hmax,
                       input int glitch_pct, input int rst_pct, input int chg_pct);
        int hc;
        hc = hmin;
        for (int i = 0; i < n; i++) begin
            if (hc == 0) begin
                clkled = ~clkled;
                hc = $urandom_range(hmax, hmin);
            end else begin
                hc--;
            end
            if (int'($urandom_range(99)) < chg_pct) begin
                value    = 16'($urandom);
                dp       = 4'($urandom);
                blank_lz = 1'($urandom);
            end
            if (int'($urandom_range(99)) < rst_pct) rst = 1'b1;
            if (clkled && int'($urandom_range(99)) < glitch_pct) begin
                clkled = 1'b0;
                cycle();
                clkled = 1'b1;
            end
            cycle();
            rst = 1'b0;
        end
    endtask

    initial begin
        // Reset held for three cycles, then scan a fixed pattern
        rst = 1'b1;
        value = 16'h1234;
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b0;
        run(250, 24, 24, 0, 0, 0);

        // Leading-zero blanking, nonzero and all-zero values
        value = 16'h0008; blank_lz = 1'b1; dp = 4'b0101;
        run(250, 20, 30, 0, 0, 0);
        value = 16'h0000;
        run(250, 20, 30, 0, 0, 0);
        value = 16'h0300; dp = 4'h0;
        run(250, 20, 30, 0, 0, 0);

        // Value changes mid-frame must not tear
        blank_lz = 1'b0; value = 16'h1111;
        run(110, 24, 24, 0, 0, 0);
        value = 16'hFFFF;
        run(300, 24, 24, 0, 0, 0);

        // Extra rise five cycles into the gap is dropped
        for (int k = 0; k < 8; k++) begin
            clkled = 1'b0;
            for (int i = 0; i < 30; i++) cycle();
            clkled = 1'b1;
            for (int i = 0; i < 6; i++) cycle();
            clkled = 1'b0;
            cycle();
            clkled = 1'b1;
            for (int i = 0; i < 30; i++) cycle();
        end

        // Held clkled keeps the current digit lit
        for (int i = 0; i < 300; i++) cycle();

        // Reset while in the gap
        clkled = 1'b0;
        cycle();
        clkled = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        run(200, 20, 30, 0, 0, 0);

        // Randomized mix of everything
        run(3000, 17, 40, 3, 1, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
